branch_predictor: RTL
=====================

# branch_predictor

- Parametrised dynamic branch predictor for the five-stage pipeline. It replaces static predict-not-taken plus flush-on-resolve.
- The IF stage queries it each cycle with the current PC and receives a predicted next PC. The stage that resolves branches and jumps reports outcomes back, which train a direct-mapped table of saturating counters and branch targets.
- The block also flags mispredictions, so the resolving stage can flush and redirect. It keeps saturating branch and mispredict counters for performance measurement.

## Interface

Parameters:
- ENTRIES, 16: number of table entries; must be a power of two ≥ 2. IDX_W = clog2(ENTRIES).
- CTR_W, 2: saturating counter width; must be ≥ 1.
- TAG_W, 8: tag width; IDX_W+2+TAG_W ≤ ADDR_W.
- ADDR_W, 32: PC and target width.

Ports (clock and reset first):
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- lk_pc, input, ADDR_W: IF-stage PC to predict.
- pred_hit, output, 1: table hit for lk_pc (combinational).
- pred_taken, output, 1: predicted taken (combinational).
- pred_next_pc, output, ADDR_W: predicted next PC (combinational).
- upd_valid, input, 1: a resolved branch or jump is presented this cycle.
- upd_pc, input, ADDR_W: PC of the resolved instruction.
- upd_taken, input, 1: actual outcome; jumps always 1.
- upd_target, input, ADDR_W: actual target when taken.
- upd_pred_taken, input, 1: prediction carried down the pipeline with the instruction.
- upd_pred_target, input, ADDR_W: pred_next_pc carried down with the instruction.
- upd_mispred, output, 1: misprediction flag for the current update (combinational).
- clear_tbl, input, 1: synchronous request to invalidate the whole table.
- ready, output, 1: table initialised; lookups and updates are active.
- cnt_br, output, 32: resolved updates counted.
- cnt_mp, output, 32: mispredicts counted.

## Operation

Indexing:
- idx = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W : IDX_W+2].
- Each entry holds {valid, tag, target[ADDR_W], ctr[CTR_W]}.

State machine (INIT, READY):
- Reset puts the block in INIT with sweep pointer 0, ready=0, cnt_br=0, cnt_mp=0.
- In INIT, the entry at the sweep pointer has valid cleared each cycle and the pointer increments.
- After the edge that clears entry ENTRIES-1, the state moves to READY.
- clear_tbl asserted in any state returns the block to INIT with the pointer at 0. The sweep restarts even mid-INIT.

Lookup:
- pred_hit = ready & valid[idx] & (tag[idx] == lk tag).
- pred_taken = pred_hit & ctr[idx][CTR_W-1].
- pred_next_pc = pred_taken ? target[idx] : lk_pc + 4, mod 2^ADDR_W.
- In INIT: pred_hit = pred_taken = 0 and pred_next_pc = lk_pc + 4.

Update (only when upd_valid & ready):
- On an entry hit, ctr saturates: increment on taken, capped at 2^CTR_W-1; decrement on not-taken, floored at 0. When taken, target ← upd_target.
- On a miss with taken, the entry is allocated or overwritten: valid=1, tag, target, ctr = 2^(CTR_W-1) (weakly taken).
- On a miss with not-taken, there is no allocation and no change.
- upd_mispred = upd_valid & ready & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)).
- cnt_br increments by 1 per accepted update; cnt_mp increments by 1 per mispredict. Both saturate at 32'hFFFFFFFF.
- In INIT, updates are ignored: no table write, no count, upd_mispred=0.

## Timing

- Lookup has zero latency: combinational from lk_pc and the current table state.
- Updates write at the rising edge. A lookup to the same index in the same cycle sees the pre-update contents; the next cycle sees the new contents.
- ready rises exactly ENTRIES rising edges after rst_n deasserts, or after the edge that samples clear_tbl=1.
- clear_tbl together with upd_valid: the clear wins and the update is dropped.
- Reset mid-operation immediately forces INIT state, pointer 0, ready=0 and both counters 0. Table contents need no async reset, because INIT invalidates them.

## Structure

- Shared package, bp_pkg:
  - state enum {BP_INIT, BP_READY}
  - weakly-taken constant function of CTR_W
  - index/tag extraction functions
- One sub-module, bp_sat_ctr: a parametrised saturating up/down counter of width W. It is used for the per-entry update value and, with W=32, for cnt_br and cnt_mp.

## Test plan

- **Reset and init.** Default params, hold rst_n=0 then release → ready=0 for 16 edges, 1 after the 16th; pred_next_pc = lk_pc+4 throughout INIT.
- **Allocation and training.**
  - Update pc=0x40, taken, target=0x100 → next cycle lookup 0x40 gives hit=1, taken=1, next_pc=0x100.
  - Two not-taken updates → taken=0, next_pc=0x44.
- **Saturation.** Ten taken updates to 0x40, then one not-taken → still predicted taken (ctr 3→2). cnt_br=11.
- **Aliasing.** Allocate 0x40, then look up 0x40+(16<<2)=0x80 (same index, different tag) → hit=0. A taken update to 0x80 evicts 0x40.
- **Mispredict flag.**
  - upd_pred_taken=1, upd_taken=1, pred_target 0x100 vs actual 0x200 → upd_mispred=1, cnt_mp increments, entry target becomes 0x200.
  - Matching prediction → upd_mispred=0.
- **Clear and collisions.**
  - clear_tbl pulsed together with an update → update dropped, ready=0 for 16 cycles, then all lookups miss.
  - rst_n asserted mid-sweep → counters at 0 and the sweep restarts from 0.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared state type and PC field helpers for branch_predictor.
package bp_pkg;

    typedef enum logic {BP_INIT, BP_READY} bp_state_e;

    // Counter value with only the MSB set: the lowest "taken" value.
    function automatic logic [31:0] weak_taken(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

    // Table index is the word address modulo the table size.
    function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w,
                                           input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: combinational saturating up/down step of a W-bit counter.
//   cur : present value
//   inc : step up, held at all-ones
//   dec : step down, held at zero
//   nxt : next value
module bp_sat_ctr #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);

    always_comb nxt = (inc && !(&cur)) ? cur + W'(1) : (dec && |cur) ? cur - W'(1) : cur;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped table of saturating counters and targets
// predicting the next PC for the IF stage, trained by resolved branches.
//   clk, rst_n                      : clock, async active-low reset
//   lk_pc -> pred_hit/pred_taken/pred_next_pc : combinational lookup
//   upd_* -> upd_mispred            : resolved outcome, combinational mispredict flag
//   clear_tbl                       : restart the invalidation sweep
//   ready                           : sweep finished, table active
//   cnt_br, cnt_mp                  : saturating update / mispredict counts
module branch_predictor import bp_pkg::*; #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              upd_mispred,
    input  logic              clear_tbl,
    output logic              ready,
    output logic [31:0]       cnt_br,
    output logic [31:0]       cnt_mp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    bp_state_e         state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [31:0]       cnt_br_q, cnt_br_d, cnt_mp_q, cnt_mp_d;

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q   [ENTRIES];

    logic [IDX_W-1:0]  lk_idx, upd_idx, wr_idx;
    logic [TAG_W-1:0]  lk_tag, upd_tag;
    logic              upd_hit, upd_acc, wr_en, wr_valid;
    logic [ADDR_W-1:0] wr_tgt;
    logic [CTR_W-1:0]  ctr_nxt, wr_ctr;

    always_comb begin
        lk_idx       = IDX_W'(pc_idx(64'(lk_pc), IDX_W));
        lk_tag       = TAG_W'(pc_tag(64'(lk_pc), IDX_W, TAG_W));
        upd_idx      = IDX_W'(pc_idx(64'(upd_pc), IDX_W));
        upd_tag      = TAG_W'(pc_tag(64'(upd_pc), IDX_W, TAG_W));
        ready        = state_q == BP_READY;
        pred_hit     = ready && valid_q[lk_idx] && tag_q[lk_idx] == lk_tag;
        pred_taken   = pred_hit && ctr_q[lk_idx][CTR_W-1];
        pred_next_pc = pred_taken ? tgt_q[lk_idx] : lk_pc + ADDR_W'(4);
        upd_hit      = valid_q[upd_idx] && tag_q[upd_idx] == upd_tag;
        upd_mispred  = upd_valid && ready &&
                       (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target));
        // A clear in the same cycle takes priority and drops the update.
        upd_acc      = upd_valid && ready && !clear_tbl;
        // INIT reuses the write port to invalidate the entry at the sweep pointer;
        // the other fields written there are don't-care.
        wr_en        = state_q == BP_INIT || (upd_acc && (upd_hit || upd_taken));
        wr_idx       = ready ? upd_idx : ptr_q;
        wr_valid     = ready;
        wr_tgt       = upd_taken ? upd_target : tgt_q[upd_idx];
        wr_ctr       = upd_hit ? ctr_nxt : CTR_W'(weak_taken(CTR_W));
        state_d      = clear_tbl ? BP_INIT :
                       (state_q == BP_INIT && ptr_q == IDX_W'(ENTRIES - 1)) ? BP_READY : state_q;
        ptr_d        = clear_tbl ? '0 : ready ? ptr_q : ptr_q + IDX_W'(1);
        cnt_br       = cnt_br_q;
        cnt_mp       = cnt_mp_q;
    end

    bp_sat_ctr #(.W(CTR_W)) u_ctr (
        .cur (ctr_q[upd_idx]),
        .inc (upd_taken),
        .dec (!upd_taken),
        .nxt (ctr_nxt)
    );

    bp_sat_ctr #(.W(32)) u_cnt_br (
        .cur (cnt_br_q),
        .inc (upd_acc),
        .dec (1'b0),
        .nxt (cnt_br_d)
    );

    bp_sat_ctr #(.W(32)) u_cnt_mp (
        .cur (cnt_mp_q),
        .inc (upd_acc && upd_mispred),
        .dec (1'b0),
        .nxt (cnt_mp_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BP_INIT;
            ptr_q    <= '0;
            cnt_br_q <= '0;
            cnt_mp_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_br_q <= cnt_br_d;
            cnt_mp_q <= cnt_mp_d;
        end
    end

    // Table storage has no reset: the INIT sweep invalidates it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            tag_q[wr_idx]   <= upd_tag;
            tgt_q[wr_idx]   <= wr_tgt;
            ctr_q[wr_idx]   <= wr_ctr;
        end
    end

endmodule
